// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: each channel toggles clk_out every hp
// clk_in cycles, with glitch-free half-period updates and a global phase-align sync.
module clock_div_multi #(
    parameter int  CHANNELS    = 4,
    parameter int  WIDTH       = 8,
    parameter int  DEFAULT_DIV = 2,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [CHANNELS-1:0] run,
    input  logic                sync,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic                div_ack,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [WIDTH-1:0]    hp       [CHANNELS];
    logic [WIDTH-1:0]    pend     [CHANNELS];
    logic [WIDTH-1:0]    cnt      [CHANNELS];
    logic [WIDTH-1:0]    pend_nxt [CHANNELS];
    logic [CHANNELS-1:0] terminal;
    logic                wr_valid;
    logic [WIDTH-1:0]    wr_value;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        wr_valid = div_wr && (int'(div_sel) < CHANNELS);
        wr_value = (div_data == '0) ? WIDTH'(1) : div_data;
        terminal = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            terminal[i] = (cnt[i] == hp[i] - WIDTH'(1));
            pend_nxt[i] = (wr_valid && div_sel == SEL_W'(i)) ? wr_value : pend[i];
        end
    end

    // NOTE: state uses non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_ack <= 1'b0;
            clk_out <= '0;
            tick    <= '0;
            // NOTE: hp/pend are register arrays, not RAM; they must reset to the default divisor.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]  <= '0;
                hp[i]   <= WIDTH'(DEFAULT_DIV);
                pend[i] <= WIDTH'(DEFAULT_DIV);
            end
        end else begin
            div_ack <= wr_valid;
            for (int i = 0; i < CHANNELS; i++) begin
                pend[i] <= pend_nxt[i];
                tick[i] <= 1'b0;
                if (sync) begin
                    // A write landing in the sync cycle is used immediately.
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    hp[i]      <= pend_nxt[i];
                end else if (run[i]) begin
                    if (terminal[i]) begin
                        // Only the already-stored pend is adopted, so a half-period never shortens mid-way.
                        cnt[i]     <= '0;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= ~clk_out[i];
                        hp[i]      <= pend[i];
                    end else begin
                        cnt[i] <= cnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a countdown-based reference model.
module tb_clock_div_multi;

    localparam int CH  = 4;
    localparam int DEF = 2;

    logic          clk_in;
    logic          rst;
    logic [CH-1:0] run;
    logic          sync;
    logic          div_wr;
    logic [1:0]    div_sel;
    logic [7:0]    div_data;
    logic          div_ack;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    logic       rst3, sync3, wr3, ack3;
    logic [2:0] run3, clk3, tick3;
    logic [1:0] sel3;
    logic [7:0] data3;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 0;

    clock_div_multi #(.CHANNELS(CH), .WIDTH(8), .DEFAULT_DIV(DEF)) u_dut (
        .clk_in(clk_in), .rst(rst), .run(run), .sync(sync),
        .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
        .div_ack(div_ack), .clk_out(clk_out), .tick(tick)
    );

    clock_div_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(DEF)) u_dut3 (
        .clk_in(clk_in), .rst(rst3), .run(run3), .sync(sync3),
        .div_wr(wr3), .div_sel(sel3), .div_data(data3),
        .div_ack(ack3), .clk_out(clk3), .tick(tick3)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: each channel counts down the cycles left in its half-period.
    int m_left [CH];
    int m_pend [CH];
    bit m_level[CH];
    bit m_tick [CH];
    bit m_ack;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_left[c] = DEF; m_pend[c] = DEF; m_level[c] = 0; m_tick[c] = 0;
        end
        m_ack = 0;
    endtask

    task automatic model_cycle();
        int w;
        bit valid;
        w     = (div_data == 0) ? 1 : int'(div_data);
        valid = div_wr && (int'(div_sel) < CH);
        m_ack = valid;
        for (int c = 0; c < CH; c++) begin
            bit hit;
            hit = valid && (int'(div_sel) == c);
            m_tick[c] = 0;
            if (sync) begin
                if (hit) m_pend[c] = w;
                m_level[c] = 0;
                m_left[c]  = m_pend[c];
            end else begin
                if (run[c]) begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        m_level[c] = ~m_level[c];
                        m_tick[c]  = m_level[c];
                        m_left[c]  = m_pend[c];
                    end
                end
                if (hit) m_pend[c] = w;
            end
        end
    endtask

    function automatic logic [8:0] model_vec();
        logic [CH-1:0] mc, mt;
        for (int c = 0; c < CH; c++) begin
            mc[c] = m_level[c];
            mt[c] = m_tick[c];
        end
        return {mc, mt, m_ack};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: wait for the edge, sample 1 time unit later, advance the model.
    task automatic step();
        @(posedge clk_in);
        #1;
        model_cycle();
        if (model_on) check("random_vs_model", {clk_out, tick, div_ack}, model_vec());
    endtask

    task automatic do_reset();
        run = '0; sync = 0; div_wr = 0; div_sel = '0; div_data = '0;
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic measure(input int ch, input int budget, output int per);
        int first;
        first = -1;
        per   = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (tick[ch]) begin
                if (first < 0) first = k;
                else begin
                    per = k - first;
                    break;
                end
            end
        end
    endtask

    typedef struct {
        logic [3:0] run;
        logic       wr;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
        logic       exp_ack;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int  per;
        bit  ok;
        int  first_tick[CH];

        // Edge n of row n-1 after reset release; ch1 gets hp=5 one cycle into a half-period.
        vecs[0]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 1'b0};
        vecs[2]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 1'b0};
        vecs[3]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 1'b0};
        vecs[4]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 1'b0};
        vecs[5]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 1'b0};
        vecs[6]  = '{4'hF, 1'b1, 2'd1, 8'd5, 4'hF, 4'h0, 1'b1};
        vecs[7]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hD, 4'hD, 1'b0};
        vecs[10] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hD, 4'h0, 1'b0};
        vecs[11] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 1'b0};
        vecs[12] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h2, 4'h2, 1'b0};
        vecs[13] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'hD, 1'b0};
        vecs[14] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 1'b0};
        vecs[15] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h2, 4'h0, 1'b0};
        vecs[16] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'h2, 4'h0, 1'b0};
        vecs[17] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'hD, 4'hD, 1'b0};

        run = '0; sync = 0; div_wr = 0; div_sel = '0; div_data = '0;
        run3 = '0; sync3 = 0; wr3 = 0; sel3 = '0; data3 = '0;
        rst = 1'b0; rst3 = 1'b0;
        #1;
        rst = 1'b1; rst3 = 1'b1;
        #2;
        check("reset_before_edge", {clk_out, tick, div_ack}, 9'd0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();

        // Power-on behaviour and glitch-free write on ch1.
        for (int i = 0; i < 18; i++) begin
            run = vecs[i].run; div_wr = vecs[i].wr; div_sel = vecs[i].sel; div_data = vecs[i].data;
            step();
            check($sformatf("vec%0d_clk", i),  clk_out, vecs[i].exp_clk);
            check($sformatf("vec%0d_tick", i), tick,    vecs[i].exp_tick);
            check($sformatf("vec%0d_ack", i),  div_ack, vecs[i].exp_ack);
        end
        div_wr = 0;

        // Zero half-period is stored as 1: divide-by-2 after the next terminal count.
        div_wr = 1; div_sel = 2'd2; div_data = 8'd0;
        step();
        div_wr = 0;
        measure(2, 40, per);
        check("ch2_period_div0", per, 2);
        measure(1, 60, per);
        check("ch1_period_hp5", per, 10);

        // Async reset mid-operation with ack high and a write still pending.
        div_wr = 1; div_sel = 2'd0; div_data = 8'd9;
        step();
        div_wr = 0;
        check("ack_before_reset", div_ack, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {clk_out, tick, div_ack}, 9'd0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        run = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("post_reset_edge%0d", k), clk_out,
                  ((k % 4) == 2 || (k % 4) == 3) ? 4'hF : 4'h0);
        end

        // Freeze ch3 for 7 cycles one cycle into its half-period.
        do_reset();
        run = 4'hF;
        for (int k = 0; k < 3; k++) step();
        run = 4'b0111;
        ok = 1;
        for (int k = 0; k < 7; k++) begin
            step();
            ok &= (clk_out[3] == 1'b1) && (tick[3] == 1'b0);
        end
        check("ch3_frozen", ok, 1'b1);
        run = 4'hF;
        step();
        check("ch3_resume_fall", clk_out[3], 1'b0);
        step();
        check("ch3_resume_low", {clk_out[3], tick[3]}, 2'b00);
        step();
        check("ch3_resume_rise", {clk_out[3], tick[3]}, 2'b11);

        // Out-of-phase channels realigned by sync; write in the sync cycle applies at once.
        do_reset();
        run = 4'hF;
        div_wr = 1; div_sel = 2'd0; div_data = 8'd3; step();
        div_sel = 2'd1; div_data = 8'd5; step();
        div_sel = 2'd2; div_data = 8'd3; step();
        div_wr = 0;
        run = 4'b1011;
        step();
        run = 4'hF;
        for (int k = 0; k < 20; k++) step();
        sync = 1; div_wr = 1; div_sel = 2'd3; div_data = 8'd4;
        step();
        sync = 0; div_wr = 0;
        check("sync_clears", {clk_out, tick}, 8'h00);
        for (int c = 0; c < CH; c++) first_tick[c] = -1;
        ok = 1;
        for (int k = 1; k <= 30; k++) begin
            step();
            ok &= (clk_out[0] == clk_out[2]);
            for (int c = 0; c < CH; c++)
                if (tick[c] && first_tick[c] < 0) first_tick[c] = k;
        end
        check("sync_equal_hp_match", ok, 1'b1);
        check("sync_ch0_first_rise", first_tick[0], 3);
        check("sync_ch1_first_rise", first_tick[1], 5);
        check("sync_ch2_first_rise", first_tick[2], 3);
        check("sync_write_ch3_rise", first_tick[3], 4);

        // Three-channel instance: writes to div_sel=3 are ignored.
        rst3 = 1'b1;
        @(posedge clk_in);
        #1;
        rst3 = 1'b0;
        run3 = 3'b111;
        wr3  = 1; sel3 = 2'd3;
        for (int k = 1; k <= 12; k++) begin
            data3 = 8'(k);
            step();
            check($sformatf("ch3inst_clk_edge%0d", k), clk3,
                  ((k % 4) == 2 || (k % 4) == 3) ? 3'b111 : 3'b000);
            check($sformatf("ch3inst_noack%0d", k), ack3, 1'b0);
        end
        sel3 = 2'd2; data3 = 8'd1;
        step();
        wr3 = 0;
        check("ch3inst_valid_ack", ack3, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        model_on = 1;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < CH; c++) run[c] = ($urandom % 8) != 0;
            sync     = ($urandom % 40) == 0;
            div_wr   = ($urandom % 6) == 0;
            div_sel  = 2'($urandom);
            div_data = 8'($urandom_range(0, 6));
            step();
        end
        model_on = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
